// File: rtl/si_byte_sample_packer_if.sv
// Simple-interface byte stream from the FT245 FIFO front end: rdy/data from
// upstream, one-cycle ack pulse back from the consumer.
interface si_byte_sample_packer_if;
  logic [7:0] rx_data_si;
  logic       rx_rdy_si;
  logic       rx_ack_si;

  modport master (output rx_data_si, output rx_rdy_si, input rx_ack_si);
  modport slave  (input rx_data_si, input rx_rdy_si, output rx_ack_si);
endinterface

// File: rtl/si_byte_sample_packer.sv
// Packs the FT245 byte stream little-endian into DAC samples, buffers them in a FIFO and
// releases one per sample_en after a prefill level. Optional macro: PACKER_UNDERRUN_CNT_EN.
module si_byte_sample_packer #(
  parameter int BYTES_PER_SAMPLE = 2,
  parameter int FIFO_AW          = 4,
  parameter int START_LEVEL      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  si_byte_sample_packer_if.slave          rx,
  input  logic                            flush,
  input  logic                            sample_en,
  output logic [8*BYTES_PER_SAMPLE-1:0]   sample_out,
  output logic                            sample_valid,
  output logic                            underrun,
  output logic [FIFO_AW:0]                fifo_level,
  output logic [15:0]                     underrun_cnt
);
  localparam int SW    = 8 * BYTES_PER_SAMPLE;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int IW    = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] START_L = (FIFO_AW + 1)'(START_LEVEL);
  localparam logic [IW-1:0]    IDX_LAST = IW'(BYTES_PER_SAMPLE - 1);

  typedef enum logic {ST_PREFILL, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 ack_q, ack_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [SW-1:0]        sample_out_q, sample_out_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 underrun_q, underrun_d;
  logic [SW-1:0]        mem [DEPTH];
  logic [SW-1:0]        assembled;
  logic                 capture, last_byte, fifo_wr, rd_en, underrun_evt;

  // An outstanding ack blocks capture, since upstream rdy is still high that cycle.
  assign capture   = rx.rx_rdy_si && !ack_q && (level_q != DEPTH_L) && !flush;
  assign last_byte = (idx_q == IDX_LAST);
  assign fifo_wr   = capture && last_byte;

  // Earlier bytes are shifted down so byte 0 ends up in the low lane.
  if (BYTES_PER_SAMPLE > 1) begin : g_pack
    logic [SW-9:0] pack_q, pack_d;
    assign assembled = {rx.rx_data_si, pack_q};
    always_comb begin
      pack_d = pack_q;
      if (flush)
        pack_d = '0;
      else if (capture && !last_byte)
        pack_d = assembled[SW-1:8];
    end
    always_ff @(posedge clk) begin
      if (rst) pack_q <= '0;
      else     pack_q <= pack_d;
    end
  end else begin : g_nopack
    assign assembled = rx.rx_data_si;
  end

  always_ff @(posedge clk) begin
    if (fifo_wr)
      mem[wr_ptr_q] <= assembled;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_PREFILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PREFILL: if (level_q >= START_L) state_d = ST_RUN;
      ST_RUN:     if (sample_en && level_q == '0) state_d = ST_PREFILL;
      default:    state_d = ST_PREFILL;
    endcase
    if (flush)
      state_d = ST_PREFILL;
  end

  // A write landing on an empty FIFO at the same edge is not bypassed to the reader.
  always_comb begin
    rd_en          = 1'b0;
    underrun_evt   = 1'b0;
    sample_valid_d = 1'b0;
    sample_out_d   = sample_out_q;
    if (flush) begin
      sample_out_d = '0;
    end else if (sample_en) begin
      if (state_q == ST_RUN && level_q != '0) begin
        rd_en          = 1'b1;
        sample_out_d   = mem[rd_ptr_q];
        sample_valid_d = 1'b1;
      end else begin
        sample_out_d = '0;
        underrun_evt = (state_q == ST_RUN);
      end
    end
  end

  always_comb begin
    ack_d      = capture;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    underrun_d = underrun_q | underrun_evt;
    if (capture)
      idx_d = last_byte ? '0 : idx_q + IW'(1);
    if (fifo_wr)
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (rd_en)
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({fifo_wr, rd_en})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
      default: level_d = level_q;
    endcase
    if (flush) begin
      idx_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q          <= 1'b0;
      idx_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      ack_q          <= ack_d;
      idx_q          <= idx_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
    end
  end

`ifdef PACKER_UNDERRUN_CNT_EN
  // Survives flush so software can read the history after recovering a stream.
  logic [15:0] ucnt_q, ucnt_d;
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_evt && ucnt_q != 16'hFFFF)
      ucnt_d = ucnt_q + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end
  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = 16'd0;
`endif

  assign rx.rx_ack_si  = ack_q;
  assign sample_out    = sample_out_q;
  assign sample_valid  = sample_valid_q;
  assign underrun      = underrun_q;
  assign fifo_level    = level_q;
endmodule

// File: tb/tb_si_byte_sample_packer.sv
// Directed bench for si_byte_sample_packer: handshake, packing, full stall,
// prefill, underrun and flush scenarios with hand-computed expectations.
module tb_si_byte_sample_packer;
  logic        clk = 1'b0;
  logic        rst, flush, sample_en;
  logic [15:0] sample_out, underrun_cnt;
  logic        sample_valid, underrun;
  logic [4:0]  fifo_level;
  int          total = 0;
  int          bad   = 0;

`ifdef PACKER_UNDERRUN_CNT_EN
  localparam logic [15:0] EXP_CNT = 16'd1;
`else
  localparam logic [15:0] EXP_CNT = 16'd0;
`endif

  always #5 clk = ~clk;

  si_byte_sample_packer_if bus();

  si_byte_sample_packer #(.BYTES_PER_SAMPLE(2), .FIFO_AW(4), .START_LEVEL(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (bus),
    .flush        (flush),
    .sample_en    (sample_en),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt)
  );

  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    bus.rx_data_si = b;
    bus.rx_rdy_si  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rx_ack_si === 1'b1) got = 1'b1;
    end
    bus.rx_rdy_si = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_timeout byte=%h got=0 need=1", b);
    end
    @(negedge clk);
    total++;
    if (bus.rx_ack_si !== 1'b0) begin
      bad++;
      $display("FAIL ack_width byte=%h got=%b need=0", b, bus.rx_ack_si);
    end
  endtask

  task automatic send_sample(input logic [15:0] s);
    send_byte(s[7:0]);
    send_byte(s[15:8]);
    $display("push sample %h level=%0d", s, fifo_level);
  endtask

  task automatic strobe();
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    $display("strobe out=%h valid=%b underrun=%b level=%0d", sample_out, sample_valid, underrun, fifo_level);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; sample_en = 1'b0;
    bus.rx_data_si = 8'h00; bus.rx_rdy_si = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if (bus.rx_ack_si !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b need=0", bus.rx_ack_si); end
    total++; if (sample_out !== 16'h0) begin bad++; $display("FAIL rst_out got=%h need=0000", sample_out); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b need=0", sample_valid); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun got=%b need=0", underrun); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d need=0", fifo_level); end
    total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d need=0", underrun_cnt); end
  endtask

  task automatic test_pack();
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
    total++; if (fifo_level !== 5'd2) begin bad++; $display("FAIL pack_level got=%0d need=2", fifo_level); end
    for (int i = 0; i < 6; i++) send_sample({8'hA0, 8'(i)});
    total++; if (fifo_level !== 5'd8) begin bad++; $display("FAIL pack_level8 got=%0d need=8", fifo_level); end
    @(negedge clk);
    strobe();
    total++; if (sample_valid !== 1'b1 || sample_out !== 16'h1234) begin bad++; $display("FAIL pack_word0 got=%h/%b need=1234/1", sample_out, sample_valid); end
    strobe();
    total++; if (sample_valid !== 1'b1 || sample_out !== 16'h5678) begin bad++; $display("FAIL pack_word1 got=%h/%b need=5678/1", sample_out, sample_valid); end
    @(negedge clk);
    total++; if (sample_valid !== 1'b0 || sample_out !== 16'h5678) begin bad++; $display("FAIL pack_hold got=%h/%b need=5678/0", sample_out, sample_valid); end
    total++; if (fifo_level !== 5'd6) begin bad++; $display("FAIL pack_level6 got=%0d need=6", fifo_level); end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 6; i++) begin
      strobe();
      total++;
      if (sample_valid !== 1'b1 || sample_out !== {8'hA0, 8'(i)}) begin
        bad++; $display("FAIL drain_%0d got=%h/%b need=%h/1", i, sample_out, sample_valid, {8'hA0, 8'(i)});
      end
    end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL drain_level got=%0d need=0", fifo_level); end
    strobe();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_flag got=%b need=1", underrun); end
    total++; if (sample_valid !== 1'b0 || sample_out !== 16'h0) begin bad++; $display("FAIL ur_out got=%h/%b need=0000/0", sample_out, sample_valid); end
    total++; if (underrun_cnt !== EXP_CNT) begin bad++; $display("FAIL ur_cnt got=%0d need=%0d", underrun_cnt, EXP_CNT); end
    send_sample(16'hBEEF);
    repeat (2) @(negedge clk);
    strobe();
    total++; if (sample_valid !== 1'b0 || sample_out !== 16'h0) begin bad++; $display("FAIL ur_prefill got=%h/%b need=0000/0", sample_out, sample_valid); end
    total++; if (fifo_level !== 5'd1 || underrun !== 1'b1) begin bad++; $display("FAIL ur_sticky got=%0d/%b need=1/1", fifo_level, underrun); end
    do_flush();
    total++; if (underrun !== 1'b0 || fifo_level !== 5'd0) begin bad++; $display("FAIL ur_flush got=%b/%0d need=0/0", underrun, fifo_level); end
    total++; if (underrun_cnt !== EXP_CNT) begin bad++; $display("FAIL ur_cnt_kept got=%0d need=%0d", underrun_cnt, EXP_CNT); end
  endtask

  task automatic test_stream();
    bus.rx_data_si = 8'h5A;
    bus.rx_rdy_si  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      total++;
      if (bus.rx_ack_si !== ((k % 2) == 1)) begin
        bad++; $display("FAIL stream_ack_%0d got=%b need=%b", k, bus.rx_ack_si, (k % 2) == 1);
      end
    end
    bus.rx_rdy_si = 1'b0;
    repeat (2) @(negedge clk);
    $display("stream done level=%0d", fifo_level);
    total++; if (fifo_level !== 5'd5) begin bad++; $display("FAIL stream_level got=%0d need=5", fifo_level); end
    do_flush();
  endtask

  task automatic test_prefill();
    for (int i = 0; i < 7; i++) send_sample(16'h0100 + 16'(i));
    repeat (2) @(negedge clk);
    total++; if (fifo_level !== 5'd7) begin bad++; $display("FAIL pre_level7 got=%0d need=7", fifo_level); end
    strobe();
    total++; if (sample_valid !== 1'b0 || sample_out !== 16'h0) begin bad++; $display("FAIL pre_strobe got=%h/%b need=0000/0", sample_out, sample_valid); end
    total++; if (fifo_level !== 5'd7) begin bad++; $display("FAIL pre_noread got=%0d need=7", fifo_level); end
    send_sample(16'h0107);
    total++; if (fifo_level !== 5'd8) begin bad++; $display("FAIL pre_level8 got=%0d need=8", fifo_level); end
    @(negedge clk);
    strobe();
    total++; if (sample_valid !== 1'b1 || sample_out !== 16'h0100) begin bad++; $display("FAIL pre_first got=%h/%b need=0100/1", sample_out, sample_valid); end
    do_flush();
  endtask

  task automatic test_full();
    logic seen;
    for (int i = 0; i < 16; i++) send_sample({8'hC0, 8'(i)});
    total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d need=16", fifo_level); end
    seen = 1'b0;
    bus.rx_data_si = 8'h99;
    bus.rx_rdy_si  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.rx_ack_si === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL full_stall got=%b need=0", seen); end
    total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_hold got=%0d need=16", fifo_level); end
    strobe();
    total++; if (sample_valid !== 1'b1 || sample_out !== 16'hC000) begin bad++; $display("FAIL full_read got=%h/%b need=c000/1", sample_out, sample_valid); end
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (bus.rx_ack_si === 1'b1) seen = 1'b1;
    end
    bus.rx_rdy_si = 1'b0;
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL full_resume got=%b need=1", seen); end
    @(negedge clk);
    total++; if (fifo_level !== 5'd15) begin bad++; $display("FAIL full_level15 got=%0d need=15", fifo_level); end
    do_flush();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) send_sample({8'hD0, 8'(i)});
    send_byte(8'hEE);
    total++; if (fifo_level !== 5'd5) begin bad++; $display("FAIL fl_level5 got=%0d need=5", fifo_level); end
    do_flush();
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL fl_level0 got=%0d need=0", fifo_level); end
    send_byte(8'h22);
    send_byte(8'h11);
    for (int i = 0; i < 7; i++) send_sample({8'hE0, 8'(i)});
    total++; if (fifo_level !== 5'd8) begin bad++; $display("FAIL fl_level8 got=%0d need=8", fifo_level); end
    @(negedge clk);
    strobe();
    total++; if (sample_valid !== 1'b1 || sample_out !== 16'h1122) begin bad++; $display("FAIL fl_fresh got=%h/%b need=1122/1", sample_out, sample_valid); end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_underrun();
    test_stream();
    test_prefill();
    test_full();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
